sprite_palette_encoder: RTL
===========================

# sprite_palette_encoder

Streaming palette encoder and writer for on-chip sprite memory. Accepts 24-bit RGB pixels in raster order over a valid/ready handshake and maps each to a 4-bit palette index. Writes the index stream to sequential addresses of a 441-entry (21×21) sprite RAM, the same format the sprite ROM readers consume. Sits between a host or pixel-stream loader and the sprite RAM write port, so sprites can be replaced at runtime instead of only through `$readmemh`.

## Interface
- `DEPTH`, 441, pixels per sprite frame; write addresses run 0..DEPTH-1
- `ADDR_W`, 9, width of the write address and miss counter
- `Clk` in 1: system clock, rising edge
- `Reset_n` in 1: asynchronous, active-low reset
- `start` in 1: begin a frame; sampled only in IDLE
- `pix_valid` in 1: `pix_rgb` is valid
- `pix_rgb` in 24: pixel colour, 8'R 8'G 8'B
- `pix_ready` out 1: encoder accepts a pixel this cycle
- `wr_en` out 1: sprite RAM write strobe
- `wr_addr` out ADDR_W: sprite RAM write address
- `wr_data` out 4: palette index
- `busy` out 1: frame in progress (RUN or DONE)
- `done` out 1: one-cycle pulse after the last write of a frame
- `miss` out 1: sticky flag; at least one pixel in the current frame had no palette match
- `miss_count` out ADDR_W: unmatched pixels in the current frame (only with `SPE_MISS_COUNT_EN`)

## Operation
- Fixed palette: 0=800080 (transparent key), 1=F83800, 2=EA9A30, 3=EF9D34, 4=227DBB, 5=FFA440, 6=AC7C00.
- Colour matching is an exact 24-bit compare. If more than one entry matches, the lowest index wins.
- An unmatched colour encodes as index 0 and sets `miss`.
- FSM states:
  - IDLE: `pix_ready`=0. `start`=1 moves to RUN, clears the pixel counter, clears `miss`, and clears `miss_count`.
  - RUN: `pix_ready`=1. A pixel is accepted when `pix_valid && pix_ready`, and the counter increments on each accept. When the accept of pixel DEPTH-1 occurs, `pix_ready` drops the next cycle and the FSM moves to DONE.
  - DONE: one cycle. `done`=1, then the FSM returns to IDLE.
- Write stage: one pipeline register.
  - The accept at edge e produces `wr_en`=1 in the following cycle, with `wr_addr` equal to the pixel ordinal and `wr_data` equal to its index.
  - A cycle with no accept produces `wr_en`=0.
  - While `wr_en`=0, `wr_addr` and `wr_data` hold their last values.
- Counter arithmetic: unsigned ADDR_W bits. The counter never exceeds DEPTH-1, so there is no wrap within a frame.
- Boundary cases:
  - `start` in RUN or DONE is ignored.
  - `pix_valid` in IDLE or DONE is ignored; no write is produced.
  - `miss` and `miss_count` hold after `done` until the next accepted `start`.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0, pipeline register empty.
- Reset asserted mid-frame: immediate return to IDLE. Any pending write is discarded, and the frame must be restarted.
- Latency from `start` sampled at edge k: RUN and `pix_ready`=1 from cycle k+1.
- Latency from pixel accept to write: 1 cycle.
- Last accept at edge e: final `wr_en` pulse in cycle e+1, `done`=1 in cycle e+2, IDLE from e+3.
- Throughput: 1 pixel/cycle. A full frame with no bubbles takes DEPTH+2 cycles from the first `pix_ready` to the end of `done`.
- `busy`=1 from cycle k+1 through the `done` cycle.

## Configuration
- `SPE_MISS_COUNT_EN` defined: `miss_count` is a saturating ADDR_W-bit counter, incremented once per unmatched accepted pixel.
- `SPE_MISS_COUNT_EN` undefined: `miss_count` is tied to 0 and its counter logic is removed. `miss` behaves identically in both builds.

## Structure
- Shared package `sprite_pkg`:
  - `PAL_SIZE`=7
  - `SPRITE_DEPTH`=441
  - `rgb_t` (24-bit) and `pal_idx_t` (4-bit) typedefs
  - the palette constant array, reused by the ROM readers
- Sub-module `palette_match`: combinational `rgb_t` → {`pal_idx_t` index, hit}. It takes its contents from the package palette.

## Test plan
- Reset: hold `Reset_n`=0 for 3 cycles → every output is 0 and `pix_ready`=0. After release with no `start`, no `wr_en` pulse ever occurs.
- Full frame, all pixels F83800, `pix_valid` constantly 1 → 441 writes, addr 0..440 with data 1. `done` is high exactly one cycle, two cycles after the last accept. `miss`=0.
- Bubbles and palette coverage:
  - Stimulus: `pix_valid` toggled 1,0,1,0; pixels cycle through the 7 palette colours.
  - Required: writes are contiguous by address with no gaps, data cycles 0..6, and `wr_en` appears only the cycle after an accept.
- Misses:
  - Stimulus: pixel 5 = 123456, pixel 9 = 000000, all others valid.
  - Required: addr 5 and addr 9 are written with data 0, and `miss` is set at the addr-5 write and stays set.
  - With `SPE_MISS_COUNT_EN`: `miss_count`=2 at `done`.
  - Without the macro: `miss_count`=0.
- Stimulus: `start` pulsed during RUN at pixel 100 and during the DONE cycle → no counter reset, and the frame completes at addr 440 normally.
- Reset mid-frame:
  - Stimulus: `Reset_n` asserted after pixel 200, then released, then a new `start` is issued.
  - Required: outputs are 0 asynchronously, the pending write is dropped, and the new frame begins at addr 0 with `miss` clear.

Source files
------------

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared sprite types, frame geometry and the fixed colour palette
// used by the palette encoder and the sprite ROM readers.
package sprite_pkg;
  localparam int PAL_SIZE = 7;
  localparam int SPRITE_DEPTH = 441;
  typedef logic [23:0] rgb_t;
  typedef logic [3:0] pal_idx_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAST, S_DONE} state_t;
  // Index 0 doubles as the transparent key and the fallback for unmatched colours
  localparam rgb_t PALETTE [PAL_SIZE] = '{
    24'h800080, 24'hF83800, 24'hEA9A30, 24'hEF9D34,
    24'h227DBB, 24'hFFA440, 24'hAC7C00
  };
endpackage

// File: rtl/palette_match.sv
// palette_match: combinational exact-match lookup of an RGB colour in the
// package palette; the lowest matching index wins.
module palette_match
  import sprite_pkg::*;
(
  input  rgb_t     i_rgb,
  output pal_idx_t o_idx,
  output logic     o_hit
);
  always_comb begin
    o_idx = '0;
    o_hit = 1'b0;
    for (int i = PAL_SIZE - 1; i >= 0; i--)
      if (i_rgb == PALETTE[i]) begin
        o_idx = pal_idx_t'(i);
        o_hit = 1'b1;
      end
  end
endmodule

// File: rtl/sprite_palette_encoder.sv
// sprite_palette_encoder: streams RGB pixels into palette indices written to sprite RAM.
// Define SPE_MISS_COUNT_EN to build the saturating per-frame miss counter.
module sprite_palette_encoder
  import sprite_pkg::*;
#(
  parameter int DEPTH  = SPRITE_DEPTH,
  parameter int ADDR_W = 9
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_pix_valid,
  input  logic [23:0]       i_pix_rgb,
  output logic              o_pix_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [3:0]        o_wr_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_miss,
  output logic [ADDR_W-1:0] o_miss_count
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_cnt, r_wr_addr;
  pal_idx_t          r_wr_data, w_idx;
  logic              r_miss, r_wr_en, w_hit, w_accept, w_last, w_start;
  palette_match u_match (.i_rgb(i_pix_rgb), .o_idx(w_idx), .o_hit(w_hit));
  assign w_start  = (r_state == S_IDLE) && i_start;
  assign w_accept = i_pix_valid && (r_state == S_RUN);
  assign w_last   = w_accept && (r_cnt == LAST);
  // S_LAST lets the final write drain so done lands one cycle after it
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = i_start ? S_RUN : S_IDLE;
      S_RUN:   w_next = w_last ? S_LAST : S_RUN;
      S_LAST:  w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_miss    <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_state <= w_next;
      r_wr_en <= w_accept;
      if (w_start) begin
        r_cnt  <= '0;
        r_miss <= 1'b0;
      end else if (w_accept) begin
        r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
        r_miss <= r_miss | ~w_hit;
      end
      if (w_accept) begin
        r_wr_addr <= r_cnt;
        r_wr_data <= w_idx;
      end
    end
`ifdef SPE_MISS_COUNT_EN
  logic [ADDR_W-1:0] r_miss_count;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_miss_count <= '0;
    else if (w_start) r_miss_count <= '0;
    else if (w_accept && !w_hit && r_miss_count != '1) r_miss_count <= r_miss_count + 1'b1;
  assign o_miss_count = r_miss_count;
`else
  assign o_miss_count = '0;
`endif
  assign o_pix_ready = r_state == S_RUN;
  assign o_busy      = r_state != S_IDLE;
  assign o_done      = r_state == S_DONE;
  assign o_wr_en     = r_wr_en;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_data   = r_wr_data;
  assign o_miss      = r_miss;
endmodule
